// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator with sub-word read-modify-write and load extension for a 64x32 data memory
module mem_access_unit #(
  parameter int DATA_W = 32,
  parameter int WORDS  = 64,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_signed,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_W-1:0]        resp_rdata,
  output logic                     resp_err,
  output logic                     busy,
  output logic [$clog2(WORDS)-1:0] mem_wr_addr,
  output logic                     mem_wr_en,
  output logic [DATA_W-1:0]        mem_wr_data,
  output logic [$clog2(WORDS)-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0]        mem_rd_data
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t             r_state, w_next;
  logic               r_we, r_signed, r_err;
  logic [1:0]         r_size;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_buf, r_rdata;
  logic               w_bad;
  logic [DATA_W-1:0]  w_sh, w_load, w_mask, w_ins, w_merge;
  assign w_bad = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign w_sh = mem_rd_data >> {r_addr[1:0], 3'b000};
  assign w_load = r_size == 2'b00 ? {{(DATA_W-8){r_signed & w_sh[7]}}, w_sh[7:0]} :
                  r_size == 2'b01 ? {{(DATA_W-16){r_signed & w_sh[15]}}, w_sh[15:0]} : mem_rd_data;
  assign w_mask = r_size == 2'b00 ? DATA_W'(8'hFF) << {r_addr[1:0], 3'b000} :
                                    DATA_W'(16'hFFFF) << {r_addr[1], 4'b0000};
  assign w_ins = r_size == 2'b00 ? {4{r_buf[7:0]}} : {2{r_buf[15:0]}};
  assign w_merge = (mem_rd_data & ~w_mask) | (w_ins & w_mask);
  assign req_ready = r_state == IDLE && !rst;
  assign busy = r_state != IDLE;
  assign resp_valid = r_state == RESP;
  assign resp_rdata = r_rdata;
  assign resp_err = r_err;
  assign mem_rd_addr = r_addr[ADDR_W-1:2];
  assign mem_wr_addr = r_addr[ADDR_W-1:2];
  assign mem_wr_data = r_buf;
  assign mem_wr_en = r_state == WRITE && !rst;
  // state register
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  // next-state selection
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (req_valid) w_next = w_bad ? RESP : (!req_we || req_size != 2'b10) ? READ : WRITE;
      READ:  w_next = r_we ? WRITE : RESP;
      WRITE: w_next = RESP;
      RESP:  if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // request latch, merge buffer and response data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we <= 1'b0;
      r_size <= 2'b00;
      r_signed <= 1'b0;
      r_addr <= '0;
      r_buf <= '0;
      r_rdata <= '0;
      r_err <= 1'b0;
    end else if (r_state == IDLE && req_valid) begin
      r_we <= req_we;
      r_size <= req_size;
      r_signed <= req_signed;
      r_addr <= req_addr;
      r_buf <= req_wdata;
      r_rdata <= '0;
      r_err <= w_bad;
    end else if (r_state == READ) begin
      if (r_we) r_buf <= w_merge;
      else r_rdata <= w_load;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard-driven checks of loads, stores, errors, backpressure and reset
module tb_mem_access_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [7:0]  req_addr = 8'h00;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid, resp_ready = 1'b0, resp_err, busy, mem_wr_en;
  logic [31:0] resp_rdata, mem_wr_data, mem_rd_data;
  logic [5:0]  mem_wr_addr, mem_rd_addr;
  logic [31:0] mem [64];
  logic [32:0] q [$];
  int checks = 0, errors = 0, cyc = 0, wr_cnt = 0, wr_cyc = 0, acc = 0;
  logic [5:0]  wr_a;
  logic [31:0] wr_d;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy), .mem_wr_addr(mem_wr_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
  assign mem_rd_data = mem[mem_rd_addr];
  always @(negedge clk) if (mem_wr_en) begin
    wr_cnt <= wr_cnt + 1;
    wr_cyc <= cyc;
    wr_a <= mem_wr_addr;
    wr_d <= mem_wr_data;
  end

  task automatic req(input logic we, input logic [1:0] size, input logic sgn,
                     input logic [7:0] addr, input logic [31:0] wdata);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL req_ready_idle got %b want 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_resp(input int lat);
    int n = 0;
    logic [32:0] e;
    while (resp_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== lat) begin errors++; $display("FAIL latency got %0d want %0d", n, lat); end
    e = q.pop_front();
    checks++;
    if ({resp_err, resp_rdata} !== e)
      begin errors++; $display("FAIL resp got err=%b rdata=%h want err=%b rdata=%h", resp_err, resp_rdata, e[32], e[31:0]); end
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL resp_valid_drop got %b want 0", resp_valid); end
  endtask

  task automatic xact(input logic we, input logic [1:0] size, input logic sgn, input logic [7:0] addr,
                      input logic [31:0] wdata, input logic [31:0] er, input logic ee, input logic [31:0] ewd);
    int w0 = wr_cnt;
    int lat = ee ? 0 : (we && size != 2'b10) ? 2 : 1;
    q.push_back({ee, er});
    req(we, size, sgn, addr, wdata);
    wait_resp(lat);
    ack();
    checks++;
    if (wr_cnt - w0 !== ((we && !ee) ? 1 : 0))
      begin errors++; $display("FAIL write_count got %0d want %0d", wr_cnt - w0, (we && !ee) ? 1 : 0); end
    if (we && !ee) begin
      checks++;
      if (wr_cyc !== acc + (size == 2'b10 ? 0 : 1))
        begin errors++; $display("FAIL write_cycle got %0d want %0d", wr_cyc - acc, size == 2'b10 ? 0 : 1); end
      checks++;
      if (wr_a !== addr[7:2] || wr_d !== ewd)
        begin errors++; $display("FAIL write got idx=%0d data=%h want idx=%0d data=%h", wr_a, wr_d, addr[7:2], ewd); end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b0 || mem_wr_en !== 1'b0 || resp_valid !== 1'b0 || busy !== 1'b0 ||
        resp_rdata !== 32'h0 || resp_err !== 1'b0)
      begin errors++; $display("FAIL reset_state got rdy=%b we=%b rv=%b busy=%b rd=%h err=%b want 0", req_ready, mem_wr_en, resp_valid, busy, resp_rdata, resp_err); end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release got %b want 1", req_ready); end
  endtask

  task automatic test_word();
    xact(1, 2'b10, 0, 8'h10, 32'hDEADBEEF, 32'h0, 0, 32'hDEADBEEF);
    xact(0, 2'b10, 0, 8'h10, 32'h0, 32'hDEADBEEF, 0, 32'h0);
  endtask

  task automatic test_byte();
    xact(1, 2'b00, 0, 8'h13, 32'h000000A5, 32'h0, 0, 32'hA5ADBEEF);
    xact(0, 2'b00, 1, 8'h13, 32'h0, 32'hFFFFFFA5, 0, 32'h0);
    xact(0, 2'b00, 0, 8'h13, 32'h0, 32'h000000A5, 0, 32'h0);
    xact(0, 2'b00, 0, 8'h12, 32'h0, 32'h000000AD, 0, 32'h0);
  endtask

  task automatic test_half();
    xact(1, 2'b10, 0, 8'h10, 32'h12348001, 32'h0, 0, 32'h12348001);
    xact(0, 2'b01, 1, 8'h12, 32'h0, 32'h00001234, 0, 32'h0);
    xact(0, 2'b01, 1, 8'h10, 32'h0, 32'hFFFF8001, 0, 32'h0);
    xact(0, 2'b01, 0, 8'h10, 32'h0, 32'h00008001, 0, 32'h0);
    xact(1, 2'b01, 0, 8'h12, 32'hFFFFBEEF, 32'h0, 0, 32'hBEEF8001);
    xact(0, 2'b00, 1, 8'h11, 32'h0, 32'hFFFFFF80, 0, 32'h0);
    xact(0, 2'b10, 0, 8'h10, 32'h0, 32'hBEEF8001, 0, 32'h0);
  endtask

  task automatic test_errors();
    xact(0, 2'b10, 0, 8'h11, 32'h0, 32'h0, 1, 32'h0);
    xact(1, 2'b01, 0, 8'h13, 32'h1234, 32'h0, 1, 32'h0);
    xact(1, 2'b11, 0, 8'h00, 32'h55, 32'h0, 1, 32'h0);
    xact(0, 2'b01, 1, 8'h12, 32'h0, 32'hFFFFBEEF, 0, 32'h0);
  endtask

  task automatic test_backpressure();
    q.push_back({1'b0, 32'hBEEF8001});
    req(0, 2'b10, 0, 8'h10, 32'h0);
    wait_resp(1);
    req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_addr = 8'h10; req_valid = 1'b1;
    q.push_back({1'b0, 32'h00000001});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hBEEF8001 || resp_err !== 1'b0 || req_ready !== 1'b0)
        begin errors++; $display("FAIL hold_%0d got rv=%b rd=%h err=%b rdy=%b want 1 beef8001 0 0", i, resp_valid, resp_rdata, resp_err, req_ready); end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL post_handshake got rv=%b rdy=%b busy=%b want 0 1 0", resp_valid, req_ready, busy); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL second_accept got busy=%b want 1", busy); end
    wait_resp(1);
    ack();
  endtask

  task automatic test_reset_write();
    int w0 = wr_cnt;
    req(1, 2'b00, 0, 8'h10, 32'h77);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", mem_wr_en); end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || wr_cnt !== w0)
      begin errors++; $display("FAIL reset_drop got busy=%b rv=%b writes=%0d want 0 0 0", busy, resp_valid, wr_cnt - w0); end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
    xact(0, 2'b10, 0, 8'h10, 32'h0, 32'hBEEF8001, 0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_backpressure();
    test_reset_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store initiator that drives the write and read ports of the 64x32 register-file data memory on behalf of the pipeline.
- Accepts byte-addressed word, halfword and byte requests over a valid/ready handshake.
- Performs read-modify-write for sub-word stores, and alignment and sign/zero extension for loads.
- Returns one response per request over a second valid/ready handshake.

Parameters:
- DATA_W, 32: memory word width; fixed at 32.
- WORDS, 64: memory depth in words; word index width = 6.
- ADDR_W, 8: byte address width; word index = req_addr[7:2].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  loads only: 1 sign-extend, 0 zero-extend.
- req_addr  in  8  byte address, little-endian lanes.
- req_wdata  in  32  store data; value taken from the low bits.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal size.
- busy  out  1  state != IDLE.
- mem_wr_addr  out  6  memory write word index.
- mem_wr_en  out  1  memory write strobe.
- mem_wr_data  out  32  memory write data.
- mem_rd_addr  out  6  memory read word index.
- mem_rd_data  in  32  memory read data, combinational from mem_rd_addr.

Behaviour:
- Reset (rst high at a clock edge):
  - state <= IDLE.
  - resp_valid, resp_err and resp_rdata <= 0.
  - Latched request fields and merge buffer <= 0.
  - req_ready = 0 and mem_wr_en = 0 while rst is high; mem_wr_en is gated with !rst.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch we, size, signed, addr and wdata.
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or size=11 -> RESP with err=1; no memory access.
  - Load -> READ.
  - Word store -> WRITE, with merge buffer = wdata.
  - Byte or half store -> READ.
- READ (one cycle):
  - mem_rd_addr = addr[7:2]; mem_rd_data is sampled at the end of the cycle.
  - Load: select the lane (byte k = addr[1:0] -> bits [8k+7:8k]; half = addr[1] -> bits [16h+15:16h]), extend per signed, store to resp_rdata -> RESP.
  - Store: merge buffer = mem_rd_data with the addressed lane replaced by wdata[7:0] or wdata[15:0] -> WRITE.
- WRITE (one cycle):
  - mem_wr_en = 1, mem_wr_addr = addr[7:2], mem_wr_data = merge buffer.
  - Next state RESP with rdata 0 and err 0.
  - mem_wr_en is high in exactly one cycle per store and never otherwise.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err are held stable until resp_ready.
  - On resp_valid && resp_ready -> IDLE; resp_valid drops the next cycle.
  - No request is accepted in the same cycle (req_ready = 0 outside IDLE).
- Latency, with the accept edge at cycle T:
  - Error: resp_valid at T+1.
  - Load: READ at T+1, resp_valid at T+2.
  - Word store: write at T+1, resp_valid at T+2.
  - Sub-word store: READ at T+1, write at T+2, resp_valid at T+3.
- Outside READ and WRITE:
  - mem_rd_addr and mem_wr_addr hold the latched word index.
  - mem_wr_data holds the merge buffer.
  - These are don't-care while mem_wr_en = 0.
- Throughput: one outstanding request; no pipelining.
- req_valid is ignored while busy; the requester must hold it until accepted.
- Reset mid-operation: the transaction is dropped, no write is issued in the reset cycle, and no response is generated.

Test Plan:
- Word store 0xDEADBEEF @0x10:
  - mem_wr_en high only at T+1, mem_wr_addr=4, mem_wr_data=0xDEADBEEF.
  - resp_valid at T+2, err=0, rdata=0.
  - Word load @0x10 -> rdata 0xDEADBEEF at T+2.
- Byte store 0x000000A5 @0x13 over 0xDEADBEEF:
  - READ at T+1; write at T+2 of 0xA5ADBEEF to index 4.
  - Byte load signed @0x13 -> 0xFFFFFFA5; unsigned -> 0x000000A5.
- Word 4 = 0x12348001, halfword loads:
  - Half signed @0x12 -> 0x00001234.
  - Half signed @0x10 -> 0xFFFF8001; unsigned @0x10 -> 0x00008001.
  - Half store 0xBEEF @0x12 -> writes 0xBEEF8001.
- Errors, each -> resp_valid at T+1, err=1, rdata=0, mem_wr_en never asserted:
  - Word load @0x11.
  - Half store @0x13.
  - size=11 @0x00.
- Backpressure:
  - Hold resp_ready=0 for 5 cycles after a load -> resp_valid, rdata and err stable; req_ready=0.
  - A second req_valid is not accepted until the cycle after the resp handshake.
- Reset during WRITE of a sub-word store:
  - rst high that cycle -> mem_wr_en=0 in that cycle.
  - Next cycle IDLE, resp_valid=0, req_ready=1 after rst drops.
